// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit processor control path: widths,
// opcode and ALU function encodings, controller states and jump conditions.
package cpu_pkg;

  localparam int OP_W    = 4;
  localparam int DATA_W  = 4;
  localparam int INSTR_W = OP_W + DATA_W;

  // Opcode encodings (instr[7:4])
  localparam logic [OP_W-1:0] OP_NOP = 4'h0;
  localparam logic [OP_W-1:0] OP_LDI = 4'h1;
  localparam logic [OP_W-1:0] OP_ADD = 4'h2;
  localparam logic [OP_W-1:0] OP_SUB = 4'h3;
  localparam logic [OP_W-1:0] OP_AND = 4'h4;
  localparam logic [OP_W-1:0] OP_OR  = 4'h5;
  localparam logic [OP_W-1:0] OP_XOR = 4'h6;
  localparam logic [OP_W-1:0] OP_NOT = 4'h7;
  localparam logic [OP_W-1:0] OP_JMP = 4'h8;
  localparam logic [OP_W-1:0] OP_JZ  = 4'h9;
  localparam logic [OP_W-1:0] OP_JC  = 4'hA;
  localparam logic [OP_W-1:0] OP_JNZ = 4'hB;
  localparam logic [OP_W-1:0] OP_HLT = 4'hF;

  // ALU function select
  localparam logic [2:0] ALU_PASS = 3'd0;
  localparam logic [2:0] ALU_ADD  = 3'd1;
  localparam logic [2:0] ALU_SUB  = 3'd2;
  localparam logic [2:0] ALU_AND  = 3'd3;
  localparam logic [2:0] ALU_OR   = 3'd4;
  localparam logic [2:0] ALU_XOR  = 3'd5;
  localparam logic [2:0] ALU_NOT  = 3'd6;

  // Jump condition select carried from the decoder to the FSM
  localparam logic [1:0] JC_ALWAYS  = 2'd0;
  localparam logic [1:0] JC_ZERO    = 2'd1;
  localparam logic [1:0] JC_CARRY   = 2'd2;
  localparam logic [1:0] JC_NOTZERO = 2'd3;

  // Controller states; the encoding is visible on the debug port
  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXECUTE = 2'd2,
    ST_HALT    = 2'd3
  } state_t;

endpackage

// File: rtl/opcode_decoder.sv
// Pure opcode classification. Reports what an instruction would do; the
// controller decides when (only in EXECUTE) these actions actually happen.
module opcode_decoder
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0] i_opcode,
  output logic [2:0]      o_alu_op,
  output logic            o_writes_acc,
  output logic            o_writes_flags,
  output logic            o_is_jump,
  output logic [1:0]      o_jump_cond,
  output logic            o_is_halt
);

  // Map each opcode to its ALU function and side effects; unused opcodes behave as NOP
  always_comb begin
    o_alu_op       = ALU_PASS;
    o_writes_acc   = 1'b0;
    o_writes_flags = 1'b0;
    o_is_jump      = 1'b0;
    o_jump_cond    = JC_ALWAYS;
    o_is_halt      = 1'b0;
    case (i_opcode)
      OP_LDI: begin
        o_alu_op     = ALU_PASS;
        o_writes_acc = 1'b1;
      end
      OP_ADD: begin
        o_alu_op       = ALU_ADD;
        o_writes_acc   = 1'b1;
        o_writes_flags = 1'b1;
      end
      OP_SUB: begin
        o_alu_op       = ALU_SUB;
        o_writes_acc   = 1'b1;
        o_writes_flags = 1'b1;
      end
      OP_AND: begin
        o_alu_op       = ALU_AND;
        o_writes_acc   = 1'b1;
        o_writes_flags = 1'b1;
      end
      OP_OR: begin
        o_alu_op       = ALU_OR;
        o_writes_acc   = 1'b1;
        o_writes_flags = 1'b1;
      end
      OP_XOR: begin
        o_alu_op       = ALU_XOR;
        o_writes_acc   = 1'b1;
        o_writes_flags = 1'b1;
      end
      OP_NOT: begin
        o_alu_op       = ALU_NOT;
        o_writes_acc   = 1'b1;
        o_writes_flags = 1'b1;
      end
      OP_JMP: begin
        o_is_jump   = 1'b1;
        o_jump_cond = JC_ALWAYS;
      end
      OP_JZ: begin
        o_is_jump   = 1'b1;
        o_jump_cond = JC_ZERO;
      end
      OP_JC: begin
        o_is_jump   = 1'b1;
        o_jump_cond = JC_CARRY;
      end
      OP_JNZ: begin
        o_is_jump   = 1'b1;
        o_jump_cond = JC_NOTZERO;
      end
      OP_HLT: begin
        o_is_halt = 1'b1;
      end
      default: begin
        o_alu_op = ALU_PASS;
      end
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Instruction-sequencing controller: FETCH -> DECODE -> EXECUTE per
// instruction, with a terminal HALT. All outputs come from the registered
// state, the instruction register and the flag inputs, never from instr.
module control_unit
  import cpu_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_run,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic               i_zero_flag,
  input  logic               i_carry_flag,
  output logic               o_pc_enable,
  output logic               o_pc_load,
  output logic [DATA_W-1:0]  o_pc_in,
  output logic [2:0]         o_alu_op,
  output logic [DATA_W-1:0]  o_imm,
  output logic               o_acc_we,
  output logic               o_flags_we,
  output logic               o_halted,
  output logic [1:0]         o_state_dbg
);

  state_t             r_state;
  state_t             w_next_state;
  logic [INSTR_W-1:0] r_ir;

  logic [2:0] w_alu_op;
  logic       w_writes_acc;
  logic       w_writes_flags;
  logic       w_is_jump;
  logic [1:0] w_jump_cond;
  logic       w_is_halt;
  logic       w_take_jump;

  opcode_decoder u_decoder (
    .i_opcode       (r_ir[INSTR_W-1:DATA_W]),
    .o_alu_op       (w_alu_op),
    .o_writes_acc   (w_writes_acc),
    .o_writes_flags (w_writes_flags),
    .o_is_jump      (w_is_jump),
    .o_jump_cond    (w_jump_cond),
    .o_is_halt      (w_is_halt)
  );

  // State and instruction register; IR only captures in FETCH while run is high
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= ST_FETCH;
      r_ir    <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == ST_FETCH && i_run) begin
        r_ir <= i_instr;
      end
    end
  end

  // Sequencing: stall in FETCH without run, HLT parks the FSM until reset
  always_comb begin
    w_next_state = ST_FETCH;
    case (r_state)
      ST_FETCH:   w_next_state = i_run ? ST_DECODE : ST_FETCH;
      ST_DECODE:  w_next_state = ST_EXECUTE;
      ST_EXECUTE: w_next_state = w_is_halt ? ST_HALT : ST_FETCH;
      ST_HALT:    w_next_state = ST_HALT;
      default:    w_next_state = ST_FETCH;
    endcase
  end

  // Resolve the jump condition against the registered flags
  always_comb begin
    w_take_jump = 1'b0;
    case (w_jump_cond)
      JC_ALWAYS:  w_take_jump = 1'b1;
      JC_ZERO:    w_take_jump = i_zero_flag;
      JC_CARRY:   w_take_jump = i_carry_flag;
      JC_NOTZERO: w_take_jump = ~i_zero_flag;
      default:    w_take_jump = 1'b0;
    endcase
  end

  // Strobes fire only in EXECUTE; each non-HLT instruction pulses exactly one of pc_enable/pc_load
  always_comb begin
    o_pc_enable = 1'b0;
    o_pc_load   = 1'b0;
    o_acc_we    = 1'b0;
    o_flags_we  = 1'b0;
    if (r_state == ST_EXECUTE && !w_is_halt) begin
      if (w_is_jump) begin
        o_pc_load   = w_take_jump;
        o_pc_enable = ~w_take_jump;
      end else begin
        o_pc_enable = 1'b1;
        o_acc_we    = w_writes_acc;
        o_flags_we  = w_writes_flags;
      end
    end
  end

  assign o_alu_op    = w_alu_op;
  assign o_imm       = r_ir[DATA_W-1:0];
  assign o_pc_in     = r_ir[DATA_W-1:0];
  assign o_halted    = (r_state == ST_HALT);
  assign o_state_dbg = r_state;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit. A small program memory and a
// ProgramCounter model surround the controller so fetched addresses and
// PC updates can be checked against hand-computed values.
module tb_control_unit;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       run = 1'b0;
   logic [7:0] instr;
   logic       zeroFlag = 1'b0;
   logic       carryFlag = 1'b0;
   logic       pcEnable;
   logic       pcLoad;
   logic [3:0] pcIn;
   logic [2:0] aluOp;
   logic [3:0] imm;
   logic       accWe;
   logic       flagsWe;
   logic       halted;
   logic [1:0] stateDbg;

   logic [7:0] progMem [16];
   logic [3:0] pcModel;

   int checks = 0;
   int errors = 0;

   control_unit dut (
      .i_clk        (clock),
      .i_reset      (reset),
      .i_run        (run),
      .i_instr      (instr),
      .i_zero_flag  (zeroFlag),
      .i_carry_flag (carryFlag),
      .o_pc_enable  (pcEnable),
      .o_pc_load    (pcLoad),
      .o_pc_in      (pcIn),
      .o_alu_op     (aluOp),
      .o_imm        (imm),
      .o_acc_we     (accWe),
      .o_flags_we   (flagsWe),
      .o_halted     (halted),
      .o_state_dbg  (stateDbg)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clock = ~clock;

   // ProgramCounter stand-in: async reset, load has priority over increment
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         pcModel <= 4'd0;
      else if (pcLoad)
         pcModel <= pcIn;
      else if (pcEnable)
         pcModel <= pcModel + 4'd1;
   end

   assign instr = progMem[pcModel];

   task automatic applyStimulus(input logic newRun, input logic newReset);
      run = newRun;
      reset = newReset;
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One instruction from a FETCH-state negedge with run high; checks DECODE, EXECUTE and the following FETCH
   task automatic runInstr(input string tag, input logic [7:0] op, input logic z, input logic c,
                           input logic expPe, input logic expPl, input logic expAcc, input logic expFlg,
                           input logic [2:0] expAlu, input logic [3:0] expPc);
      progMem[pcModel] = op;
      zeroFlag = z;
      carryFlag = c;
      @(negedge clock);
      checkOutput($sformatf("%s/decState", tag), 8'(stateDbg), 8'd1);
      checkOutput($sformatf("%s/decStrobes", tag), 8'({pcEnable, pcLoad, accWe, flagsWe}), 8'd0);
      @(negedge clock);
      checkOutput($sformatf("%s/exState", tag), 8'(stateDbg), 8'd2);
      checkOutput($sformatf("%s/pcEnable", tag), 8'(pcEnable), 8'(expPe));
      checkOutput($sformatf("%s/pcLoad", tag), 8'(pcLoad), 8'(expPl));
      checkOutput($sformatf("%s/accWe", tag), 8'(accWe), 8'(expAcc));
      checkOutput($sformatf("%s/flagsWe", tag), 8'(flagsWe), 8'(expFlg));
      checkOutput($sformatf("%s/aluOp", tag), 8'(aluOp), 8'(expAlu));
      checkOutput($sformatf("%s/imm", tag), 8'(imm), 8'(op[3:0]));
      checkOutput($sformatf("%s/pcIn", tag), 8'(pcIn), 8'(op[3:0]));
      @(negedge clock);
      checkOutput($sformatf("%s/fetchState", tag), 8'(stateDbg), 8'd0);
      checkOutput($sformatf("%s/nextPc", tag), 8'(pcModel), 8'(expPc));
   endtask

   // Directed sequence: reset, NOP sweep with wrap, ALU ops, jumps, stall, mid-EXECUTE reset, halt
   initial begin
      for (int i = 0; i < 16; i++) progMem[i] = 8'h00;
      #1 applyStimulus(1'b0, 1'b1);
      @(negedge clock);
      @(negedge clock);
      checkOutput("reset/state", 8'(stateDbg), 8'd0);
      checkOutput("reset/strobes", 8'({pcEnable, pcLoad, accWe, flagsWe}), 8'd0);
      checkOutput("reset/halted", 8'(halted), 8'd0);
      checkOutput("reset/aluOp", 8'(aluOp), 8'd0);
      checkOutput("reset/imm", 8'(imm), 8'd0);
      checkOutput("reset/pcIn", 8'(pcIn), 8'd0);
      applyStimulus(1'b1, 1'b0);

      for (int i = 0; i < 16; i++)
         runInstr($sformatf("nop%0d", i), 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'((i + 1) % 16));

      runInstr("ldi",  8'h15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'd1);
      runInstr("add",  8'h23, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 4'd2);
      runInstr("sub",  8'h31, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd2, 4'd3);
      runInstr("and",  8'h4C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd3, 4'd4);
      runInstr("or",   8'h56, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4, 4'd5);
      runInstr("xor",  8'h69, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd5, 4'd6);
      runInstr("not",  8'h70, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'd6, 4'd7);
      runInstr("opC",  8'hC4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd8);
      runInstr("jmp",  8'h8A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd10);
      runInstr("jzT",  8'h97, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd7);
      runInstr("jzF",  8'h97, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd8);
      runInstr("jcT",  8'hA7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd7);
      runInstr("jcF",  8'hA7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd8);
      runInstr("jnzT", 8'hB7, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd7);
      runInstr("jnzF", 8'hB7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd8);

      applyStimulus(1'b0, 1'b0);
      progMem[8] = 8'h2F;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         checkOutput($sformatf("stall%0d/state", i), 8'(stateDbg), 8'd0);
         checkOutput($sformatf("stall%0d/strobes", i), 8'({pcEnable, pcLoad, accWe, flagsWe}), 8'd0);
         checkOutput($sformatf("stall%0d/irImm", i), 8'(imm), 8'd7);
         checkOutput($sformatf("stall%0d/irAlu", i), 8'(aluOp), 8'd0);
         checkOutput($sformatf("stall%0d/pc", i), 8'(pcModel), 8'd8);
      end

      progMem[8] = 8'h23;
      applyStimulus(1'b1, 1'b0);
      @(negedge clock);
      @(negedge clock);
      checkOutput("rstEx/accWeBefore", 8'(accWe), 8'd1);
      checkOutput("rstEx/pcEnableBefore", 8'(pcEnable), 8'd1);
      #1 applyStimulus(1'b0, 1'b1);
      #1;
      checkOutput("rstEx/accWe", 8'(accWe), 8'd0);
      checkOutput("rstEx/pcEnable", 8'(pcEnable), 8'd0);
      checkOutput("rstEx/flagsWe", 8'(flagsWe), 8'd0);
      checkOutput("rstEx/state", 8'(stateDbg), 8'd0);
      checkOutput("rstEx/imm", 8'(imm), 8'd0);
      checkOutput("rstEx/aluOp", 8'(aluOp), 8'd0);
      #1 applyStimulus(1'b0, 1'b0);
      @(negedge clock);
      checkOutput("rstEx/pcAfter", 8'(pcModel), 8'd0);
      applyStimulus(1'b1, 1'b0);
      runInstr("resumeLdi", 8'h15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'd1);

      progMem[1] = 8'hF0;
      @(negedge clock);
      checkOutput("hlt/decState", 8'(stateDbg), 8'd1);
      @(negedge clock);
      checkOutput("hlt/exState", 8'(stateDbg), 8'd2);
      checkOutput("hlt/exStrobes", 8'({pcEnable, pcLoad, accWe, flagsWe}), 8'd0);
      checkOutput("hlt/exHalted", 8'(halted), 8'd0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         checkOutput($sformatf("halt%0d/state", i), 8'(stateDbg), 8'd3);
         checkOutput($sformatf("halt%0d/halted", i), 8'(halted), 8'd1);
         checkOutput($sformatf("halt%0d/strobes", i), 8'({pcEnable, pcLoad, accWe, flagsWe}), 8'd0);
         checkOutput($sformatf("halt%0d/pc", i), 8'(pcModel), 8'd1);
         applyStimulus(1'(i % 2), 1'b0);
      end
      #2 applyStimulus(1'b1, 1'b1);
      #1;
      checkOutput("haltRst/halted", 8'(halted), 8'd0);
      checkOutput("haltRst/state", 8'(stateDbg), 8'd0);
      #1 applyStimulus(1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Instruction-sequencing FSM for the 4-bit processor.
- Each cycle it drives the program counter's pc_enable, pc_load and pc_in, the ALU operation select, and the accumulator and flag write enables.
- It fetches an 8-bit instruction from program memory at the current PC and runs a fixed FETCH -> DECODE -> EXECUTE sequence.
- It sits between program memory, the ProgramCounter, the ALU/accumulator and the flag register.

Parameters:
- OP_W, 4, opcode width (instr[7:4]).
- DATA_W, 4, operand/immediate width (instr[3:0]); also the PC width.
- INSTR_W, OP_W+DATA_W (8), instruction word width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  when low, FSM holds in FETCH without fetching; when high, sequencing proceeds.
- instr  in  8  program-memory word at address pc_out (pc_out comes from the ProgramCounter).
- zero_flag  in  1  registered Z flag from the flag register.
- carry_flag  in  1  registered C flag from the flag register.
- pc_enable  out  1  one-cycle PC increment strobe.
- pc_load  out  1  one-cycle PC load strobe.
- pc_in  out  4  PC load target (= IR operand).
- alu_op  out  3  ALU function: 0 PASS_B, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 NOT.
- imm  out  4  immediate operand to ALU B input (= IR[3:0]).
- acc_we  out  1  accumulator write strobe.
- flags_we  out  1  flag register write strobe.
- halted  out  1  high while in HALT.
- state_dbg  out  2  encoded state (FETCH=0, DECODE=1, EXECUTE=2, HALT=3).

Behaviour:
- Reset (async, any state, mid-instruction included):
  - state = FETCH, IR = 8'h00.
  - All strobes = 0, alu_op = 0, pc_in = 0, imm = 0, halted = 0.
  - Outputs go low immediately, not at the next edge.
- FETCH:
  - If run = 1: IR <= instr; next state DECODE.
  - If run = 0: stay in FETCH, IR unchanged.
  - No strobes asserted.
- DECODE: no strobes; next state EXECUTE. alu_op, imm and pc_in already reflect the IR.
- EXECUTE (single cycle; always returns to FETCH except HLT). Opcode actions:
  - 0 NOP: pc_enable=1.
  - 1 LDI: alu_op=PASS_B, acc_we=1, pc_enable=1. Flags are not written.
  - 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 7 NOT: alu_op per map, acc_we=1, flags_we=1, pc_enable=1.
  - 8 JMP: pc_load=1, pc_in=IR[3:0].
  - 9 JZ: if zero_flag, pc_load=1; else pc_enable=1.
  - A JC: same as JZ, conditioned on carry_flag.
  - B JNZ: same as JZ, conditioned on !zero_flag.
  - C-E: treated as NOP.
  - F HLT: no strobes; next state HALT.
- HALT:
  - All strobes 0, halted=1. Only reset exits; run is ignored.
- Strobe rules:
  - pc_enable and pc_load are mutually exclusive and never both high.
  - Exactly one of them pulses per non-HLT instruction, for exactly 1 cycle.
  - acc_we and flags_we are high only in EXECUTE.
- Latency: 3 cycles per instruction with run held high. The PC update is visible on pc_out at the edge ending EXECUTE.
- Flag timing: conditional jumps sample flags during EXECUTE. Flags written by the previous instruction's EXECUTE are valid, because there are at least 2 intervening cycles.
- Output generation: outputs are combinational from the registered state, the IR and the flag inputs. There is no path from instr to any output.
- run deasserted outside FETCH: the current instruction completes; the FSM then stalls in FETCH.
- PC wrap: pc_enable at PC=15 wraps to 0 inside the PC. The controller does nothing special.
- Illegal state encoding: not reachable. Default branch goes to FETCH.

Decomposition:
- Package cpu_pkg:
  - opcode constants OP_NOP…OP_HLT.
  - alu_op constants ALU_PASS…ALU_NOT.
  - state enum/localparams.
  - INSTR_W, DATA_W.
- Sub-module opcode_decoder (combinational): maps opcode to {alu_op, writes_acc, writes_flags, is_jump, jump_cond[1:0], is_halt}. The FSM gates these outputs with state == EXECUTE.

Test Plan:
- Reset then run=1, memory all NOP (8'h00) -> pc_enable pulses every 3rd cycle; pc_out goes 0,1,2…; 15 wraps to 0; pc_load never high.
- instr=8'h15 (LDI 5) -> in EXECUTE: alu_op=0, imm=5, acc_we=1, flags_we=0, pc_enable=1. Then instr=8'h23 (ADD 3) -> alu_op=1, imm=3, acc_we=1, flags_we=1.
- instr=8'h8A (JMP 10) -> EXECUTE: pc_load=1, pc_in=4'hA, pc_enable=0; next fetch from pc_out=10.
- JZ 8'h97 with zero_flag=1 -> pc_load=1, pc_in=7. Same with zero_flag=0 -> pc_enable=1 only. JNZ 8'hB7 and JC 8'hA7 checked both ways.
- instr=8'hF0 (HLT) -> halted=1 and state_dbg=3 from the next cycle; no strobes for 20 cycles with run toggling. Assert reset -> halted=0, state_dbg=0 without waiting for a clock edge.
- run=0 held for 5 cycles in FETCH -> no strobes, IR unchanged. Assert reset during EXECUTE of ADD -> acc_we/pc_enable drop immediately; resume with run=1 at FETCH.
